// File: rtl/memory_cell_arbiter_pkg.sv
// Shared types and helpers for the activation-memory arbiter.
//   ADDR_W     : memory address width (4096-entry address space).
//   src_t      : per-read response source tag (none / port A / port B / error).
//   addr_legal : true when an address falls inside the populated depth.
package lstm_mem_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_ERR  = 2'd3
  } src_t;

  // Zero-extend to 32 bits so the compare against the signed depth is exact.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input int depth);
    return int'({{(32-ADDR_W){1'b0}}, addr}) < depth;
  endfunction

endpackage

// File: rtl/memory_cell_arbiter_if.sv
// Bundle of requester, response and memory-port signals around the arbiter.
//   w_*        : write request (valid/ready, address, data)
//   r0_*, r1_* : read requests (valid/ready, address) and responses
//                (rvalid, rdata, rerr)
//   mem_*      : memory port A (write or read) and port B (read), plus the
//                memory's registered read data
//   err_flag   : sticky out-of-range indication
//   rr_ptr     : round-robin pointer, visible for debug (0 = r0 favoured)
//
// Handshake: a request transfers in any cycle where valid and ready are both
// high. Ready is a combinational function of the valids and addresses, so a
// requester must never derive valid from ready. Read responses arrive exactly
// one cycle after the transfer and cannot be back-pressured.
interface memory_cell_arbiter_if #(
  parameter int WIDTH = 32
) ();
  import lstm_mem_pkg::*;

  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;

  logic              r0_valid;
  logic              r0_ready;
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_rvalid;
  logic [WIDTH-1:0]  r0_rdata;
  logic              r0_rerr;

  logic              r1_valid;
  logic              r1_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic              r1_rvalid;
  logic [WIDTH-1:0]  r1_rdata;
  logic              r1_rerr;

  logic              mem_wr_a;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [WIDTH-1:0]  mem_i_a;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [WIDTH-1:0]  mem_o_a;
  logic [WIDTH-1:0]  mem_o_b;

  logic              err_flag;
  logic              rr_ptr;

  // Environment side: requesters plus the memory instance.
  modport master (
    output w_valid, w_addr, w_data,
    output r0_valid, r0_addr, r1_valid, r1_addr,
    output mem_o_a, mem_o_b,
    input  w_ready, r0_ready, r1_ready,
    input  r0_rvalid, r0_rdata, r0_rerr,
    input  r1_rvalid, r1_rdata, r1_rerr,
    input  mem_wr_a, mem_addr_a, mem_i_a, mem_addr_b,
    input  err_flag, rr_ptr
  );

  // Arbiter side.
  modport slave (
    input  w_valid, w_addr, w_data,
    input  r0_valid, r0_addr, r1_valid, r1_addr,
    input  mem_o_a, mem_o_b,
    output w_ready, r0_ready, r1_ready,
    output r0_rvalid, r0_rdata, r0_rerr,
    output r1_rvalid, r1_rdata, r1_rerr,
    output mem_wr_a, mem_addr_a, mem_i_a, mem_addr_b,
    output err_flag, rr_ptr
  );

endinterface

// File: rtl/memory_cell_arbiter_rsp.sv
// Per-requester read response tracker.
//   clk, rst  : clock, asynchronous active-low reset
//   src_next  : source granted this cycle (SRC_NONE when nothing accepted)
//   mem_o_a/b : memory registered read data
//   rvalid, rdata, rerr : response presented the cycle after the accept
//   tag       : current tag, exposed for debug
module mem_arb_rsp
  import lstm_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  src_t             src_next,
  input  logic [WIDTH-1:0] mem_o_a,
  input  logic [WIDTH-1:0] mem_o_b,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             rerr,
  output src_t             tag
);

  // Reloaded every cycle: a tag lives for exactly the one response cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag <= SRC_NONE;
    else      tag <= src_next;
  end

  always_comb begin
    rdata = '0;
    case (tag)
      SRC_A:   rdata = mem_o_a;
      SRC_B:   rdata = mem_o_b;
      default: rdata = '0;
    endcase
  end

  assign rvalid = (tag != SRC_NONE);
  assign rerr   = (tag == SRC_ERR);

endmodule

// File: rtl/memory_cell_arbiter.sv
// Arbiter sharing one dual-port activation memory between a write requester
// and two read requesters.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : requester handshakes/responses and memory port signals
// Writes always own port A when legal. Reads are granted port B first, then
// port A when no legal write is present; rr_ptr picks the port-B winner when
// both reads are eligible and flips only on such contended cycles.
module memory_cell_arbiter
  import lstm_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM      = 2809,
  parameter int TIMESTEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  memory_cell_arbiter_if.slave bus
);

  localparam int DEPTH = NUM * TIMESTEP;

  logic w_legal, w_go;
  logic r0_legal, r1_legal;
  logic r0_elig, r1_elig, contended;
  logic rr_ptr_q, err_q;
  src_t src0, src1;
  src_t tag0, tag1;

  assign w_legal  = addr_legal(bus.w_addr, DEPTH);
  assign w_go     = bus.w_valid & w_legal;
  assign r0_legal = addr_legal(bus.r0_addr, DEPTH);
  assign r1_legal = addr_legal(bus.r1_addr, DEPTH);

  // A read to the address being written this cycle waits a cycle so it sees
  // the new data instead of the stale word.
  assign r0_elig   = bus.r0_valid & r0_legal & ~(w_go & (bus.r0_addr == bus.w_addr));
  assign r1_elig   = bus.r1_valid & r1_legal & ~(w_go & (bus.r1_addr == bus.w_addr));
  assign contended = r0_elig & r1_elig;

  // Grant decision: which source (if any) serves each read this cycle.
  always_comb begin
    src0 = SRC_NONE;
    src1 = SRC_NONE;
    if (bus.r0_valid && !r0_legal) src0 = SRC_ERR;
    if (bus.r1_valid && !r1_legal) src1 = SRC_ERR;
    if (contended) begin
      if (!rr_ptr_q) begin
        src0 = SRC_B;
        src1 = w_go ? SRC_NONE : SRC_A;
      end else begin
        src1 = SRC_B;
        src0 = w_go ? SRC_NONE : SRC_A;
      end
    end else if (r0_elig) begin
      src0 = SRC_B;
    end else if (r1_elig) begin
      src1 = SRC_B;
    end
  end

  assign bus.w_ready  = bus.w_valid;
  assign bus.r0_ready = (src0 != SRC_NONE);
  assign bus.r1_ready = (src1 != SRC_NONE);

  // Memory port drive; idle ports park at address 0.
  always_comb begin
    bus.mem_addr_a = '0;
    bus.mem_addr_b = '0;
    if (w_go)                bus.mem_addr_a = bus.w_addr;
    else if (src0 == SRC_A)  bus.mem_addr_a = bus.r0_addr;
    else if (src1 == SRC_A)  bus.mem_addr_a = bus.r1_addr;
    if (src0 == SRC_B)       bus.mem_addr_b = bus.r0_addr;
    else if (src1 == SRC_B)  bus.mem_addr_b = bus.r1_addr;
  end

  assign bus.mem_wr_a = w_go;
  assign bus.mem_i_a  = bus.w_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (contended) rr_ptr_q <= ~rr_ptr_q;
      err_q <= err_q | (bus.w_valid & ~w_legal) | (src0 == SRC_ERR) | (src1 == SRC_ERR);
    end
  end

  assign bus.err_flag = err_q;
  assign bus.rr_ptr   = rr_ptr_q;

  mem_arb_rsp #(.WIDTH(WIDTH)) u_rsp0 (
    .clk      (clk),
    .rst      (rst),
    .src_next (src0),
    .mem_o_a  (bus.mem_o_a),
    .mem_o_b  (bus.mem_o_b),
    .rvalid   (bus.r0_rvalid),
    .rdata    (bus.r0_rdata),
    .rerr     (bus.r0_rerr),
    .tag      (tag0)
  );

  mem_arb_rsp #(.WIDTH(WIDTH)) u_rsp1 (
    .clk      (clk),
    .rst      (rst),
    .src_next (src1),
    .mem_o_a  (bus.mem_o_a),
    .mem_o_b  (bus.mem_o_b),
    .rvalid   (bus.r1_rvalid),
    .rdata    (bus.r1_rdata),
    .rerr     (bus.r1_rerr),
    .tag      (tag1)
  );

endmodule

// File: tb/tb_memory_cell_arbiter.sv
module tb_memory_cell_arbiter;
  import lstm_mem_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 2809;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  memory_cell_arbiter_if #(.WIDTH(W)) bus ();

  memory_cell_arbiter #(.WIDTH(W), .NUM(2809), .TIMESTEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory_cell stand-in: registered dual-port ----------------
  logic [W-1:0] mem_arr [0:4095];
  always @(posedge clk) begin
    if (bus.mem_wr_a) mem_arr[bus.mem_addr_a] <= bus.mem_i_a;
    bus.mem_o_a <= mem_arr[bus.mem_addr_a];
    bus.mem_o_b <= mem_arr[bus.mem_addr_b];
  end

  // ---------------- reference model state ----------------
  logic [W-1:0]   shadow [0:4095];
  logic [W+1:0]   exp_q0[$];
  logic [W+1:0]   exp_q1[$];
  int             rr_m;
  bit             err_m;

  function automatic logic [W-1:0] init_val(input int i);
    return 32'hC0DE_0000 | i;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit wv, input int wa, input logic [W-1:0] wd,
                       input bit v0, input int a0, input bit v1, input int a1);
    bus.w_valid  = wv;
    bus.w_addr   = wa[11:0];
    bus.w_data   = wd;
    bus.r0_valid = v0;
    bus.r0_addr  = a0[11:0];
    bus.r1_valid = v1;
    bus.r1_addr  = a1[11:0];
  endtask

  task automatic drive_idle();
    drive(0, 0, '0, 0, 0, 0, 0);
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    bit           wv, w_leg, w_go;
    int           wa;
    logic [W-1:0] wd;
    bit           rv[2], leg[2], elig[2];
    int           ra[2], port[2], order[2];
    int           freep[$];
    int           n_elig;
    logic [W-1:0] e_addr_a, e_addr_b;
    logic [W+1:0] e;
    bit           act_ready[2], act_rv[2], act_re[2];
    logic [W-1:0] act_rd[2];
    #1;
    wv = bus.w_valid; wa = int'(bus.w_addr); wd = bus.w_data;
    rv[0] = bus.r0_valid; ra[0] = int'(bus.r0_addr);
    rv[1] = bus.r1_valid; ra[1] = int'(bus.r1_addr);
    act_ready[0] = bus.r0_ready; act_ready[1] = bus.r1_ready;
    act_rv[0] = bus.r0_rvalid; act_re[0] = bus.r0_rerr; act_rd[0] = bus.r0_rdata;
    act_rv[1] = bus.r1_rvalid; act_re[1] = bus.r1_rerr; act_rd[1] = bus.r1_rdata;

    w_leg = (wa < DEPTH);
    w_go  = wv && w_leg;
    for (int k = 0; k < 2; k++) begin
      leg[k]  = (ra[k] < DEPTH);
      elig[k] = rv[k] && leg[k] && !(w_go && ra[k] == wa);
      port[k] = 0;
    end
    // Free ports handed out in priority order: B first, A only without a write.
    freep.push_back(2);
    if (!w_go) freep.push_back(1);
    order[0] = rr_m; order[1] = 1 - rr_m;
    n_elig = 0;
    for (int i = 0; i < 2; i++) begin
      if (elig[order[i]]) begin
        n_elig++;
        if (freep.size() > 0) port[order[i]] = freep.pop_front();
      end
    end
    e_addr_a = w_go ? W'(wa) : '0;
    e_addr_b = '0;
    for (int k = 0; k < 2; k++) begin
      if (port[k] == 1) e_addr_a = W'(ra[k]);
      if (port[k] == 2) e_addr_b = W'(ra[k]);
    end

    for (int k = 0; k < 2; k++) begin
      if (k == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
      else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
      chk($sformatf("r%0d_rvalid", k), W'(act_rv[k]), W'(e[W+1]));
      chk($sformatf("r%0d_rerr", k),   W'(act_re[k]), W'(e[W]));
      chk($sformatf("r%0d_rdata", k),  act_rd[k], e[W-1:0]);
      chk($sformatf("r%0d_ready", k),  W'(act_ready[k]),
          W'(rv[k] && (!leg[k] || port[k] != 0)));
    end
    chk("w_ready",    W'(bus.w_ready), W'(wv));
    chk("mem_wr_a",   W'(bus.mem_wr_a), W'(w_go));
    chk("mem_addr_a", W'(bus.mem_addr_a), e_addr_a);
    chk("mem_addr_b", W'(bus.mem_addr_b), e_addr_b);
    chk("mem_i_a",    bus.mem_i_a, wd);
    chk("err_flag",   W'(bus.err_flag), W'(err_m));
    chk("rr_ptr",     W'(bus.rr_ptr), W'(rr_m));

    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rv[k] && !leg[k])  e = {1'b1, 1'b1, {W{1'b0}}};
      else if (port[k] != 0) e = {1'b1, 1'b0, shadow[ra[k]]};
      else                   e = '0;
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      if (rv[k] && !leg[k]) err_m = 1'b1;
    end
    if (wv && !w_leg) err_m = 1'b1;
    if (w_go) shadow[wa] = wd;
    if (n_elig == 2) rr_m = 1 - rr_m;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting mid-cycle; pending responses are dropped.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_r0_rvalid", W'(bus.r0_rvalid), '0);
    chk("rst_r1_rvalid", W'(bus.r1_rvalid), '0);
    exp_q0.delete();
    exp_q1.delete();
    rr_m  = 0;
    err_m = 1'b0;
    drive_idle();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit           wv;
    int           wa;
    logic [W-1:0] wd;
    bit           v0;
    int           a0;
    bit           v1;
    int           a1;
    bit           e_w_ready;
    bit           e_r0_ready;
    bit           e_r1_ready;
    int           e_addr_b;
  } vec_t;

  vec_t vecs [15];

  function automatic int rand_addr();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(2809, 4095));
    return int'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = init_val(i);
      shadow[i]  = init_val(i);
    end
    rr_m  = 0;
    err_m = 1'b0;
    rst   = 1'b0;
    drive_idle();

    //          wv wa    wd            v0 a0    v1 a1   w  r0 r1 addr_b
    vecs[0]  = '{0, 0,    32'h0,        0, 0,    0, 0,   0, 0, 0, 0};    // idle
    vecs[1]  = '{1, 5,    32'hA5A5A5A5, 0, 0,    0, 0,   1, 0, 0, 0};    // write 5
    vecs[2]  = '{0, 0,    32'h0,        1, 5,    0, 0,   0, 1, 0, 5};    // read back 5
    vecs[3]  = '{0, 0,    32'h0,        1, 10,   1, 20,  0, 1, 1, 10};   // contended x4
    vecs[4]  = '{0, 0,    32'h0,        1, 10,   1, 20,  0, 1, 1, 20};
    vecs[5]  = '{0, 0,    32'h0,        1, 10,   1, 20,  0, 1, 1, 10};
    vecs[6]  = '{0, 0,    32'h0,        1, 10,   1, 20,  0, 1, 1, 20};
    vecs[7]  = '{1, 7,    32'h77777777, 0, 0,    1, 7,   1, 0, 0, 0};    // hazard
    vecs[8]  = '{0, 0,    32'h0,        0, 0,    1, 7,   0, 0, 1, 7};    // re-issue
    vecs[9]  = '{0, 0,    32'h0,        1, 2809, 0, 0,   0, 1, 0, 0};    // illegal read
    vecs[10] = '{0, 0,    32'h0,        0, 0,    0, 0,   0, 0, 0, 0};
    vecs[11] = '{1, 2900, 32'h12345678, 0, 0,    0, 0,   1, 0, 0, 0};    // illegal write
    vecs[12] = '{1, 100,  32'hBEEF0001, 1, 30,   1, 40,  1, 1, 0, 30};   // write steals A
    vecs[13] = '{1, 101,  32'hBEEF0002, 1, 30,   1, 40,  1, 0, 1, 40};
    vecs[14] = '{0, 0,    32'h0,        1, 50,   1, 60,  0, 1, 1, 50};   // leaves rr_ptr=1

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Reset state after release.
    #1;
    chk("reset_r0_rvalid", W'(bus.r0_rvalid), '0);
    chk("reset_r1_rvalid", W'(bus.r1_rvalid), '0);
    chk("reset_r0_rdata",  bus.r0_rdata, '0);
    chk("reset_r1_rerr",   W'(bus.r1_rerr), '0);
    chk("reset_err_flag",  W'(bus.err_flag), '0);
    chk("reset_mem_wr_a",  W'(bus.mem_wr_a), '0);
    chk("reset_rr_ptr",    W'(bus.rr_ptr), '0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1);
      #1;
      chk($sformatf("vec%0d_w_ready", i),  W'(bus.w_ready),  W'(vecs[i].e_w_ready));
      chk($sformatf("vec%0d_r0_ready", i), W'(bus.r0_ready), W'(vecs[i].e_r0_ready));
      chk($sformatf("vec%0d_r1_ready", i), W'(bus.r1_ready), W'(vecs[i].e_r1_ready));
      chk($sformatf("vec%0d_addr_b", i),   W'(bus.mem_addr_b), W'(vecs[i].e_addr_b));
      step();
      // Hand-derived response checks for the key corner cases.
      if (i == 2) begin
        chk("wr_then_rd_rdata", bus.r0_rdata, 32'hA5A5A5A5);
        chk("wr_then_rd_rerr",  W'(bus.r0_rerr), '0);
      end
      if (i == 8) chk("hazard_reissue_rdata", bus.r1_rdata, 32'h77777777);
      if (i == 9) begin
        chk("illegal_rvalid", W'(bus.r0_rvalid), 32'd1);
        chk("illegal_rerr",   W'(bus.r0_rerr), 32'd1);
        chk("illegal_rdata",  bus.r0_rdata, '0);
        chk("illegal_err_flag", W'(bus.err_flag), 32'd1);
      end
      if (i == 11) chk("err_flag_sticky", W'(bus.err_flag), 32'd1);
    end

    // Reset while r0 has a read in flight.
    drive(0, 0, '0, 1, 3, 0, 0);
    step();
    apply_reset();
    #1;
    chk("post_rst_r0_rvalid", W'(bus.r0_rvalid), '0);
    chk("post_rst_rr_ptr",    W'(bus.rr_ptr), '0);
    chk("post_rst_err_flag",  W'(bus.err_flag), '0);
    drive(0, 0, '0, 1, 11, 1, 12);
    #1;
    chk("post_rst_r0_wins_b", W'(bus.mem_addr_b), 32'd11);
    step();

    // Randomized traffic against the model, with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset();
      drive($urandom_range(0, 1) == 1, rand_addr(), $urandom(),
            $urandom_range(0, 3) != 0, rand_addr(),
            $urandom_range(0, 3) != 0, rand_addr());
      step();
    end
    drive_idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_cell_arbiter.md
# memory_cell_arbiter

Shares the dual-port activation memory (`memory_cell`) between one write requester (forward pass storing activations) and two read requesters (backprop and weight-update readers). Each cycle it grants the memory ports, checks addresses against the memory depth, and stalls same-address write/read hazards. It also routes the memory's one-cycle-latency read data back to the read requester that issued each access. It sits directly between the LSTM datapath stages and one `memory_cell` instance.

## Interface
Parameters:
- `WIDTH`, 32: data width; must match `memory_cell`.
- `NUM`, 2809: cells per timestep.
- `TIMESTEP`, 1: timesteps stored; `NUM*TIMESTEP` ≤ 4096.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `w_valid`, in, 1 / `w_ready`, out, 1: write request handshake.
- `w_addr`, in, 12 / `w_data`, in, WIDTH: write address and data.
- `rK_valid`, in, 1 / `rK_ready`, out, 1 (K = 0, 1): read request handshake.
- `rK_addr`, in, 12: read address.
- `rK_rvalid`, out, 1 / `rK_rdata`, out, WIDTH / `rK_rerr`, out, 1: read response.
- `mem_wr_a`, out, 1 / `mem_addr_a`, out, 12 / `mem_i_a`, out, WIDTH: to memory port A.
- `mem_addr_b`, out, 12: to memory port B.
- `mem_o_a`, `mem_o_b`, in, WIDTH: memory registered read data.
- `err_flag`, out, 1: sticky flag; set on any out-of-range request.

## Operation
- A request transfers when valid and ready are both high in the same cycle.
- Ready is combinational from the valids and addresses. Requesters must not make valid depend on ready.
- Range check: an address is legal when `addr < NUM*TIMESTEP`.
- Write path:
  - `w_ready` = `w_valid`; writes are never stalled.
  - Legal write: port A is driven with `mem_wr_a=1`, `mem_addr_a=w_addr`, `mem_i_a=w_data`.
  - Illegal write: the request is accepted, nothing is issued to memory, and `err_flag` is set.
- Read eligibility: a read is eligible when valid, legal, and not hazarded.
  - Hazard: `w_valid` is high, the write is legal, and `rK_addr == w_addr`. A hazarded read has `rK_ready=0` that cycle, so it re-issues and returns the new data.
- Read grant rules:
  - One eligible read: it gets port B.
  - Two eligible reads: the one selected by `rr_ptr` gets port B. The other gets port A if no legal write is present; otherwise it gets `ready=0`.
  - `rr_ptr` flips to the port-B loser only when both reads were eligible.
- Illegal read: `ready=1` without using any port. It sets `err_flag` and produces an error response.
- Response tracking: each read keeps a registered tag {NONE, A, B, ERR}, loaded at accept.
  - `rK_rvalid` = (tag ≠ NONE).
  - `rK_rdata` = `mem_o_a` for A, `mem_o_b` for B, 0 for ERR or NONE.
  - `rK_rerr` = (tag == ERR).
  - Responses have no backpressure.
- Idle memory ports drive address 0 and `mem_wr_a=0`.
- `mem_i_a` always equals `w_data`.

## Timing
- Reset (asynchronous, `rst`=0):
  - Tags go to NONE, so `rK_rvalid=0`, `rK_rdata=0`, `rK_rerr=0`.
  - `err_flag=0`, `rr_ptr=0` (r0 favoured).
  - Combinational outputs follow their inputs.
- Reset mid-operation: outstanding responses are dropped; memory contents are untouched.
- Read latency: accepted in cycle t, response in cycle t+1 (exactly 1 cycle).
- Back-to-back reads from the same requester are accepted every cycle, so full throughput is one read per requester per cycle.
- Write lands at the edge ending the accept cycle. A read accepted at t+1 or later to that address returns the new data.
- `err_flag` rises at the edge after the illegal accept and holds until reset.
- `rr_ptr` updates at the end of each contended cycle.

## Structure
- Package `lstm_mem_pkg`:
  - `ADDR_W=12`.
  - Tag enum `src_t {SRC_NONE, SRC_A, SRC_B, SRC_ERR}`.
  - Range-check function.
- Sub-module `mem_arb_rsp`, instantiated once per read requester:
  - Holds the tag register.
  - Contains the `rdata`/`rvalid`/`rerr` output mux.
- The top level holds the grant logic, `rr_ptr` and `err_flag`.

## Test plan
- Reset release then idle → all `rvalid=0`, `err_flag=0`, `mem_wr_a=0`.
- Write addr 5 data 0xA5A5A5A5, then r0 reads addr 5 the next cycle → `r0_rvalid` one cycle after accept, `rdata=0xA5A5A5A5`, `rerr=0`.
- r0 and r1 both valid (addrs 10, 20) for 4 cycles with no write → both accepted every cycle (one on A, one on B). Port B alternates r0, r1, r0, r1; data matches preloaded contents.
- Write addr 7 and r1 read addr 7 in the same cycle → `r1_ready=0` that cycle; the re-issued read returns the new data.
- r0 reads addr 2809 (NUM=2809, TIMESTEP=1) → accepted; next cycle `rvalid=1`, `rerr=1`, `rdata=0`; `err_flag` high and stays high.
- Assert `rst` low while r0 has an accepted read in flight → no response the following cycle; `rr_ptr` back to r0.
